lm07_poll_sched: RTL and testbench

Scheduler that shares one LM07 SPI read engine among `N_SENS` temperature sensors on a common SCK/SIO bus with one chip-select each. It sequences periodic poll rounds and on-demand reads, drives the per-sensor CS lines around each engine transaction, and times out stuck transfers. It also latches the latest reading per sensor and raises per-sensor over-temperature alarms. It sits between the system control logic and the LM07 reader, and feeds the display path.

---
 rtl/lm07_poll_sched_if.sv | 36 +++
 rtl/lm07_poll_sched.sv | 242 ++++++++++++++++++++++++
 tb/tb_lm07_poll_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lm07_poll_sched_if.sv
// Bus bundle between the LM07 poll scheduler and its surroundings: system
// control (enable, on-demand requests, threshold), the shared SPI read
// engine, the chip-select lines and the reading/alarm outputs.
interface lm07_poll_sched_if #(
    parameter int N_SENS = 4
);
    logic              en;
    logic              req_valid;
    logic [2:0]        req_idx;
    logic              req_ready;
    logic [7:0]        thresh;
    logic              eng_start;
    logic              eng_done;
    logic [7:0]        eng_data;
    logic [N_SENS-1:0] cs_n;
    logic              temp_valid;
    logic [2:0]        temp_idx;
    logic [7:0]        temp_data;
    logic [N_SENS-1:0] alarm;
    logic              timeout_err;
    logic              overrun;

    // Environment side: drives control, requests and engine responses.
    modport master (
        output en, req_valid, req_idx, thresh, eng_done, eng_data,
        input  req_ready, eng_start, cs_n, temp_valid, temp_idx, temp_data,
               alarm, timeout_err, overrun
    );

    // Scheduler side.
    modport slave (
        input  en, req_valid, req_idx, thresh, eng_done, eng_data,
        output req_ready, eng_start, cs_n, temp_valid, temp_idx, temp_data,
               alarm, timeout_err, overrun
    );
endinterface

// File: rtl/lm07_poll_sched.sv
// Shares one LM07 read engine among N_SENS sensors. Periodic poll rounds set
// a pending mask; a single on-demand slot takes priority. Each transaction is
// framed by its chip select (SETUP/START/WAIT/GUARD), aborted on timeout, and
// completed readings update the latched value and sticky over-temp alarms.
module lm07_poll_sched #(
    parameter int N_SENS   = 4,
    parameter int POLL_DIV = 1000,
    parameter int TIMEOUT  = 64
) (
    input  logic             SYSCLK,
    input  logic             RSTN,
    lm07_poll_sched_if.slave bus
);
    localparam int PW = $clog2(POLL_DIV);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0]     POLL_LAST = PW'(POLL_DIV - 1);
    localparam logic [WW-1:0]     WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0]     WAIT_FIRST = WW'(1);
    localparam logic [N_SENS-1:0] ALL_ONES = {N_SENS{1'b1}};
    localparam logic [N_SENS-1:0] NONE     = {N_SENS{1'b0}};
    localparam logic [N_SENS-1:0] ONE      = {{(N_SENS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GUARD = 3'd4
    } state_t;

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [2:0] lowest_set(input logic [N_SENS-1:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_SENS - 1; i >= 0; i--) begin
            idx = m[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [N_SENS-1:0] onehot(input logic [2:0] idx);
        return ONE << idx;
    endfunction

    state_t            r_state;
    logic [PW-1:0]     r_poll_cnt;
    logic [N_SENS-1:0] r_pend;
    logic              r_slot_vld;
    logic [2:0]        r_slot_idx;
    logic              r_req_ready;
    logic [2:0]        r_sel;
    logic              r_from_slot;
    logic [WW-1:0]     r_wait_cnt;
    logic [N_SENS-1:0] r_cs_n;
    logic              r_eng_start;
    logic              r_temp_valid;
    logic [2:0]        r_temp_idx;
    logic [7:0]        r_temp_data;
    logic [N_SENS-1:0] r_alarm;
    logic              r_timeout_err;
    logic              r_overrun;

    state_t            w_state_nxt;
    logic [2:0]        w_sel_nxt;
    logic              w_from_slot_nxt;
    logic [N_SENS-1:0] w_cs_n_nxt;
    logic              w_start_nxt;
    logic              w_done_end;
    logic              w_to_end;
    logic              w_end;
    logic              w_tick;
    logic              w_accept;
    logic              w_hot;
    logic [N_SENS-1:0] w_clr;

    assign w_tick   = bus.en && (r_poll_cnt == POLL_LAST);
    assign w_accept = bus.req_valid && r_req_ready &&
                      ({1'b0, bus.req_idx} < 4'(N_SENS));
    assign w_end    = w_done_end | w_to_end;
    assign w_clr    = (w_end && !r_from_slot) ? onehot(r_sel) : NONE;
    assign w_hot    = $signed(bus.eng_data) >= $signed(bus.thresh);

    // Next state, selection and next values of the registered bus outputs.
    // An on-demand request arriving in IDLE is selected directly so that CS
    // falls on the very next cycle; it still occupies the slot until done.
    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_from_slot_nxt = r_from_slot;
        w_cs_n_nxt      = ALL_ONES;
        w_start_nxt     = 1'b0;
        w_done_end      = 1'b0;
        w_to_end        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_slot_vld) begin
                    w_sel_nxt       = r_slot_idx;
                    w_from_slot_nxt = 1'b1;
                    w_state_nxt     = S_SETUP;
                    w_cs_n_nxt      = ~onehot(r_slot_idx);
                end else if (w_accept) begin
                    w_sel_nxt       = bus.req_idx;
                    w_from_slot_nxt = 1'b1;
                    w_state_nxt     = S_SETUP;
                    w_cs_n_nxt      = ~onehot(bus.req_idx);
                end else if (r_pend != NONE) begin
                    w_sel_nxt       = lowest_set(r_pend);
                    w_from_slot_nxt = 1'b0;
                    w_state_nxt     = S_SETUP;
                    w_cs_n_nxt      = ~onehot(lowest_set(r_pend));
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                w_cs_n_nxt  = ~onehot(r_sel);
                w_start_nxt = 1'b1;
                w_state_nxt = S_START;
            end
            S_START: begin
                w_cs_n_nxt  = ~onehot(r_sel);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.eng_done) begin
                    w_done_end  = 1'b1;
                    w_state_nxt = S_GUARD;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_to_end    = 1'b1;
                    w_state_nxt = S_GUARD;
                end else begin
                    w_cs_n_nxt = ~onehot(r_sel);
                end
            end
            S_GUARD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register and transaction bookkeeping.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_sel       <= 3'd0;
            r_from_slot <= 1'b0;
            r_wait_cnt  <= {WW{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_from_slot <= w_from_slot_nxt;
            if (r_state == S_START) begin
                r_wait_cnt <= WAIT_FIRST;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
        end
    end

    // Poll timer and pending mask; a tick merges all sensors into the mask.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_poll_cnt <= {PW{1'b0}};
            r_pend     <= NONE;
            r_overrun  <= 1'b0;
        end else begin
            if (!bus.en) begin
                r_poll_cnt <= {PW{1'b0}};
            end else if (r_poll_cnt == POLL_LAST) begin
                r_poll_cnt <= {PW{1'b0}};
            end else begin
                r_poll_cnt <= r_poll_cnt + PW'(1);
            end
            r_pend    <= (r_pend & ~w_clr) | (w_tick ? ALL_ONES : NONE);
            r_overrun <= w_tick && (r_pend != NONE);
        end
    end

    // On-demand slot: filled on accept, emptied when its transaction ends.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_slot_vld  <= 1'b0;
            r_slot_idx  <= 3'd0;
            r_req_ready <= 1'b1;
        end else if (w_end && r_from_slot) begin
            r_slot_vld  <= 1'b0;
            r_req_ready <= 1'b1;
        end else if (w_accept) begin
            r_slot_vld  <= 1'b1;
            r_slot_idx  <= bus.req_idx;
            r_req_ready <= 1'b0;
        end else begin
            r_slot_vld  <= r_slot_vld;
            r_req_ready <= r_req_ready;
        end
    end

    // Registered outputs: chip selects, engine start, reading and alarms.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cs_n        <= ALL_ONES;
            r_eng_start   <= 1'b0;
            r_temp_valid  <= 1'b0;
            r_temp_idx    <= 3'd0;
            r_temp_data   <= 8'd0;
            r_alarm       <= NONE;
            r_timeout_err <= 1'b0;
        end else begin
            r_cs_n        <= w_cs_n_nxt;
            r_eng_start   <= w_start_nxt;
            r_temp_valid  <= w_done_end;
            r_timeout_err <= w_to_end;
            if (w_done_end) begin
                r_temp_idx  <= r_sel;
                r_temp_data <= bus.eng_data;
            end else begin
                r_temp_idx  <= r_temp_idx;
                r_temp_data <= r_temp_data;
            end
            if (w_done_end && w_hot) begin
                r_alarm <= r_alarm | onehot(r_sel);
            end else begin
                r_alarm <= r_alarm;
            end
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.eng_start   = r_eng_start;
    assign bus.cs_n        = r_cs_n;
    assign bus.temp_valid  = r_temp_valid;
    assign bus.temp_idx    = r_temp_idx;
    assign bus.temp_data   = r_temp_data;
    assign bus.alarm       = r_alarm;
    assign bus.timeout_err = r_timeout_err;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_lm07_poll_sched.sv
// Directed bench for lm07_poll_sched: a table of on-demand reads plus
// hand-written sequences for poll rounds, overrun, timeout and async reset.
module tb_lm07_poll_sched;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lm07_poll_sched_if #(.N_SENS(4)) bus();

    lm07_poll_sched #(.N_SENS(4), .POLL_DIV(100), .TIMEOUT(64)) dut (
        .SYSCLK (clk),
        .RSTN   (rstn),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [2:0] idx;
        logic [7:0] thr;
        int         dly;        // 0: engine never answers
        logic [7:0] val;
        logic [3:0] exp_cs;
        int         exp_start;
        int         exp_tv;
        int         exp_to;
        logic [3:0] exp_alarm;
    } vec_t;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine model: answers eng_val on eng_done eng_delay cycles after eng_start.
    int         eng_delay = 0;
    logic [7:0] eng_val   = 8'd0;
    initial begin
        int   cnt;
        logic armed;
        cnt   = 0;
        armed = 1'b0;
        bus.eng_done = 1'b0;
        bus.eng_data = 8'd0;
        forever begin
            @(negedge clk);
            bus.eng_data = eng_val;
            if (!rstn) begin
                armed = 1'b0;
                bus.eng_done = 1'b0;
            end else if (bus.eng_start) begin
                cnt   = eng_delay;
                armed = (eng_delay > 0);
                bus.eng_done = 1'b0;
            end else if (armed) begin
                cnt   = cnt - 1;
                bus.eng_done = (cnt == 0);
                armed = (cnt != 0);
            end else begin
                bus.eng_done = 1'b0;
            end
        end
    end

    // Monitor: event counts, timestamps and the sequence of readings.
    int         n_starts = 0, n_tv = 0, n_to = 0, n_ovr = 0, cs_multi = 0;
    int         start_cyc = 0, tv_cyc = 0, to_cyc = 0;
    logic [3:0] cs_at_start = 4'hF;
    logic [2:0] tv_idx_q[$];
    logic [7:0] tv_dat_q[$];
    initial begin
        forever begin
            @(negedge clk);
            if ($countones(~bus.cs_n) > 1) cs_multi++;
            if (bus.eng_start) begin
                n_starts++;
                start_cyc   = cyc;
                cs_at_start = bus.cs_n;
            end
            if (bus.temp_valid) begin
                n_tv++;
                tv_cyc = cyc;
                tv_idx_q.push_back(bus.temp_idx);
                tv_dat_q.push_back(bus.temp_data);
            end
            if (bus.timeout_err) begin
                n_to++;
                to_cyc = cyc;
            end
            if (bus.overrun) n_ovr++;
        end
    end

    initial begin
        vec_t tbl[8];
        int   exp_ord[6];
        int   acc, s0, t0, o0, v0, first_to;

        tbl[0] = '{3'd2, 8'd30,  5, 8'd25,  4'b1011, 1, 1, 0, 4'b0000};
        tbl[1] = '{3'd1, 8'hEC,  3, 8'hE2,  4'b1101, 1, 1, 0, 4'b0000};
        tbl[2] = '{3'd3, 8'd30,  7, 8'd30,  4'b0111, 1, 1, 0, 4'b1000};
        tbl[3] = '{3'd0, 8'd31,  2, 8'd30,  4'b1110, 1, 1, 0, 4'b1000};
        tbl[4] = '{3'd3, 8'd100, 4, 8'h80,  4'b0111, 1, 1, 0, 4'b1000};
        tbl[5] = '{3'd0, 8'h80,  1, 8'h80,  4'b1110, 1, 1, 0, 4'b1001};
        tbl[6] = '{3'd1, 8'h80,  0, 8'h7F,  4'b1101, 1, 0, 1, 4'b1001};
        tbl[7] = '{3'd5, 8'h80,  3, 8'h7F,  4'b1111, 0, 0, 0, 4'b1001};
        exp_ord = '{0, 3, 1, 0, 2, 3};

        bus.en        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_idx   = 3'd0;
        bus.thresh    = 8'd30;
        rstn          = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cs_n",      int'(bus.cs_n),        4'hF);
        check("rst_eng_start", int'(bus.eng_start),   0);
        check("rst_temp_vld",  int'(bus.temp_valid),  0);
        check("rst_timeout",   int'(bus.timeout_err), 0);
        check("rst_overrun",   int'(bus.overrun),     0);
        check("rst_temp_idx",  int'(bus.temp_idx),    0);
        check("rst_temp_data", int'(bus.temp_data),   0);
        check("rst_alarm",     int'(bus.alarm),       0);
        check("rst_req_ready", int'(bus.req_ready),   1);
        rstn = 1'b1;
        @(negedge clk);

        // Poll round: four sensors in order, en dropped mid-round
        eng_delay = 20;
        eng_val   = 8'd25;
        bus.thresh = 8'd30;
        tv_idx_q.delete();
        tv_dat_q.delete();
        t0 = n_tv;
        bus.en = 1'b1;
        for (int k = 0; k < 300 && n_starts == 0; k++) @(negedge clk);
        bus.en = 1'b0;
        for (int k = 0; k < 400 && n_tv < t0 + 4; k++) @(negedge clk);
        repeat (150) @(negedge clk);
        check("poll_tv_count", n_tv - t0, 4);
        for (int i = 0; i < 4; i++) begin
            check("poll_order", (i < tv_idx_q.size()) ? int'(tv_idx_q[i]) : -1, i);
            check("poll_data",  (i < tv_dat_q.size()) ? int'(tv_dat_q[i]) : -1, 25);
        end
        check("poll_cs_onehot", cs_multi, 0);
        check("poll_alarm",     int'(bus.alarm), 0);
        check("poll_overrun",   n_ovr, 0);

        // Table of on-demand reads with en = 0
        for (int v = 0; v < 8; v++) begin
            s0 = n_starts;
            t0 = n_tv;
            o0 = n_to;
            bus.thresh = tbl[v].thr;
            eng_delay  = tbl[v].dly;
            eng_val    = tbl[v].val;
            check("vec_ready_idle", int'(bus.req_ready), 1);
            bus.req_valid = 1'b1;
            bus.req_idx   = tbl[v].idx;
            acc = cyc;
            @(negedge clk);
            bus.req_valid = 1'b0;
            check("vec_ready_after", int'(bus.req_ready), 1 - tbl[v].exp_start);
            check("vec_cs_setup",    int'(bus.cs_n), int'(tbl[v].exp_cs));
            for (int k = 0; k < 10 && n_starts == s0; k++) @(negedge clk);
            check("vec_starts", n_starts - s0, tbl[v].exp_start);
            if (n_starts != s0) check("vec_start_lat", start_cyc - acc, 2);
            for (int k = 0; k < 100 && n_tv == t0 && n_to == o0; k++) @(negedge clk);
            check("vec_temp_valid", n_tv - t0, tbl[v].exp_tv);
            check("vec_timeout",    n_to - o0, tbl[v].exp_to);
            if (n_tv != t0) begin
                check("vec_tv_lat",    tv_cyc - start_cyc, tbl[v].dly + 1);
                check("vec_temp_idx",  int'(tv_idx_q[$]), int'(tbl[v].idx));
                check("vec_temp_data", int'(tv_dat_q[$]), int'(tbl[v].val));
            end
            if (n_to != o0) check("vec_to_lat", to_cyc - start_cyc, 64);
            repeat (3) @(negedge clk);
            check("vec_alarm", int'(bus.alarm), int'(tbl[v].exp_alarm));
        end

        // Overrun: slow engine, second tick mid-round, request mid-round
        eng_delay  = 40;
        eng_val    = 8'd25;
        bus.thresh = 8'd30;
        tv_idx_q.delete();
        tv_dat_q.delete();
        t0 = n_tv;
        v0 = n_ovr;
        bus.en = 1'b1;
        for (int k = 0; k < 300 && n_tv == t0; k++) @(negedge clk);
        check("ovr_ready", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_idx   = 3'd3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 300 && n_ovr == v0; k++) @(negedge clk);
        bus.en = 1'b0;
        for (int k = 0; k < 600 && n_tv < t0 + 6; k++) @(negedge clk);
        repeat (100) @(negedge clk);
        check("ovr_count",    n_ovr - v0, 1);
        check("ovr_tv_count", n_tv - t0, 6);
        for (int i = 0; i < 6; i++) begin
            check("ovr_order", (i < tv_idx_q.size()) ? int'(tv_idx_q[i]) : -1, exp_ord[i]);
        end
        check("ovr_cs_onehot", cs_multi, 0);
        check("ovr_alarm",     int'(bus.alarm), 4'b1001);

        // Timeout inside a poll round: CS released, next sensor served
        eng_delay = 0;
        s0 = n_starts;
        t0 = n_tv;
        o0 = n_to;
        bus.en = 1'b1;
        for (int k = 0; k < 300 && n_to == o0; k++) @(negedge clk);
        bus.en = 1'b0;
        first_to = to_cyc - start_cyc;
        check("to_latency", first_to, 64);
        check("to_cs_released", int'(bus.cs_n), 4'hF);
        for (int k = 0; k < 10 && n_starts < s0 + 2; k++) @(negedge clk);
        check("to_next_sensor_cs", int'(cs_at_start), 4'b1101);
        for (int k = 0; k < 400 && n_to < o0 + 4; k++) @(negedge clk);
        check("to_count",    n_to - o0, 4);
        check("to_no_valid", n_tv - t0, 0);

        // Async reset during WAIT
        repeat (5) @(negedge clk);
        eng_delay = 0;
        s0 = n_starts;
        bus.req_valid = 1'b1;
        bus.req_idx   = 3'd1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 10 && n_starts == s0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("rstw_cs_low", int'(bus.cs_n), 4'b1101);
        #2 rstn = 1'b0;
        #1;
        check("rstw_cs_async", int'(bus.cs_n),      4'hF);
        check("rstw_alarm",    int'(bus.alarm),     0);
        check("rstw_ready",    int'(bus.req_ready), 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        s0 = n_starts;
        o0 = n_to;
        repeat (150) @(negedge clk);
        check("rstw_no_start",   n_starts - s0, 0);
        check("rstw_no_timeout", n_to - o0, 0);
        check("rstw_cs_idle",    int'(bus.cs_n), 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
